// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage program counter and its return-address stack.
package pc_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } pc_state_t;

    localparam int RAS_DEPTH_DEFAULT = 4;

    // Index width for a RAS of the given depth; a depth below 2 still gets one bit.
    function automatic int ras_idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int PC_WIDTH  = 11,
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] push_data,
    output logic [PC_WIDTH-1:0] top,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    output logic                underflow
);

    localparam int IDX_W = ras_idx_w(RAS_DEPTH);
    localparam logic [IDX_W-1:0] PTR_ONE   = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE   = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   CNT_DEPTH = (IDX_W + 1)'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] mem [RAS_DEPTH];
    logic [IDX_W-1:0]    wr_ptr;
    logic [IDX_W-1:0]    top_idx;
    logic [IDX_W:0]      count;
    logic                do_pop;

    assign top_idx   = wr_ptr - PTR_ONE;
    assign top       = mem[top_idx];
    assign empty     = (count == '0);
    assign full      = (count == CNT_DEPTH);
    assign do_pop    = pop && !empty;
    // A pop on an empty stack is only flagged; any push in the same cycle still proceeds.
    assign underflow = pop && empty;
    assign overflow  = push && !do_pop && full;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_pop) begin
            wr_ptr <= top_idx;
            count  <= count - CNT_ONE;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
            if (!full) begin
                count <= count + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: stepped increment, stall hold, redirect with a one-cycle
// bubble, call/return through a return-address stack, and a terminal halt.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int PC_WIDTH     = 11,
    parameter int RESET_VECTOR = 0,
    parameter int STEP         = 1,
    parameter int RAS_DEPTH    = RAS_DEPTH_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                call,
    input  logic                ret,
    input  logic                halt_req,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                fetch_valid,
    output logic                halted,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    localparam logic [PC_WIDTH-1:0] STEP_INC = PC_WIDTH'(STEP);
    localparam logic [PC_WIDTH-1:0] RV_PC    = PC_WIDTH'(RESET_VECTOR);

    // Wraps modulo 2^PC_WIDTH by truncation; no carry is reported.
    function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
        return pc + STEP_INC;
    endfunction

    pc_state_t           state;
    logic                active;
    logic                ras_push;
    logic                ras_pop;
    logic                ras_empty;
    logic                ras_full;
    logic                ras_ovf_pulse;
    logic                ras_unf_pulse;
    logic                ret_taken;
    logic [PC_WIDTH-1:0] ras_top;

    assign active    = (state != HALT) && !halt_req;
    assign ret_taken = ret && !ras_empty;

    always_comb begin
        ras_pop  = 1'b0;
        ras_push = 1'b0;
        if (active) begin
            ras_pop  = ret;
            // A taken return drops any concurrent redirect, including its push.
            ras_push = redirect_valid && call && !ret_taken;
        end
    end

    ras_stack #(
        .PC_WIDTH (PC_WIDTH),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clock    (clock),
        .reset    (reset),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_inc(pc_out)),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full),
        .overflow (ras_ovf_pulse),
        .underflow(ras_unf_pulse)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= BUBBLE;
            pc_out        <= RV_PC;
            fetch_valid   <= 1'b0;
            halted        <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (ras_ovf_pulse) begin
                ras_overflow <= 1'b1;
            end
            if (ras_unf_pulse) begin
                ras_underflow <= 1'b1;
            end
            if (state != HALT) begin
                if (halt_req) begin
                    state       <= HALT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b1;
                end else if (ret_taken) begin
                    state       <= BUBBLE;
                    pc_out      <= ras_top;
                    fetch_valid <= 1'b0;
                end else if (redirect_valid) begin
                    state       <= BUBBLE;
                    pc_out      <= redirect_target;
                    fetch_valid <= 1'b0;
                end else if (state == BUBBLE) begin
                    // The bubble is held while downstream stalls; the PC does not move.
                    if (!stall) begin
                        state       <= RUN;
                        fetch_valid <= 1'b1;
                    end
                end else if (!stall) begin
                    pc_out <= pc_inc(pc_out);
                end
            end
        end
    end

    logic unused_full;
    assign unused_full = ras_full;

endmodule
